alu_sched: RTL and testbench

- Two-requester scheduler for the shared 4-bit ALU (combinational; ports a, b, op, out, z, n, o, c).
- Accepts operation requests from two clients over valid/ready handshakes.
- Arbitrates round-robin, drives the ALU from registered operands and captures the result and flags.
- Returns each result to the issuing client over a response handshake with backpressure.
- Sits between the Basys3 front-end logic (switch/button sources) and the ALU instance.

---
 rtl/alu_sched_pkg.sv | 26 ++
 rtl/alu.sv | 48 ++++
 rtl/alu_sched_rr_arb2.sv | 38 +++
 rtl/alu_sched.sv | 131 +++++++++++++
 tb/tb_alu_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and opcode constants for the ALU scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS_A  = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ILLEGAL = 3'b010;
  localparam logic [2:0] OP_SUB_BA  = 3'b011;
  localparam logic [2:0] OP_NOT_A   = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_OR      = 3'b110;
  localparam logic [2:0] OP_XOR     = 3'b111;

  typedef struct packed {
    logic z;
    logic n;
    logic o;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 4-bit ALU with zero/negative/overflow/carry flags
module alu
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W:0]   out,
  output logic              z,
  output logic              n,
  output logic              o,
  output logic              c
);

  logic [DATA_W:0] res;
  logic            ovf;

  // Result and signed-overflow per opcode; carry is the extra result bit (borrow for subtract)
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_PASS_A: res = {1'b0, a};
      OP_ADD: begin
        res = {1'b0, a} + {1'b0, b};
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB_BA: begin
        res = {1'b0, b} - {1'b0, a};
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != b[DATA_W-1]);
      end
      OP_NOT_A: res = {1'b0, ~a};
      OP_AND:   res = {1'b0, a & b};
      OP_OR:    res = {1'b0, a | b};
      OP_XOR:   res = {1'b0, a ^ b};
      default:  res = '0;
    endcase
  end

  assign out = res;
  assign z   = (res[DATA_W-1:0] == '0);
  assign n   = res[DATA_W-1];
  assign o   = ovf;
  assign c   = res[DATA_W];

endmodule

// File: rtl/alu_sched_rr_arb2.sv
// rtl/alu_sched_rr_arb2.sv - two-way round-robin arbiter, pointer advances on accept
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Lone requester always wins; on a tie the pointer picks the winner
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // After an accept, priority moves to the client that did not win
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = ~gnt_o[1];
  end

  // Pointer register, client 0 favoured out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-client request/response scheduler in front of a shared ALU
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int          DATA_W     = 4,
  parameter int          OP_W       = 3,
  parameter logic [2:0]  ILLEGAL_OP = 3'b010
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W:0]     rsp_out,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W:0]     alu_out,
  input  logic [3:0]          alu_flags,
  output logic                busy
);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                err_q, err_d;
  logic [DATA_W:0]     out_q, out_d;
  flags_t              flags_q, flags_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;

  logic                accept;
  logic                gnt_idx;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [OP_W-1:0]     sel_op;

  rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req_valid),
    .en_i     (state_q == IDLE),
    .accept_i (accept),
    .gnt_o    (req_ready)
  );

  assign accept  = |(req_valid & req_ready);
  assign gnt_idx = req_ready[1];
  assign sel_a   = gnt_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign sel_b   = gnt_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign sel_op  = gnt_idx ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];

  // Next-state: accept in IDLE, one settle cycle in EXEC, hold response until owner takes it
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    err_d    = err_q;
    out_d    = out_q;
    flags_d  = flags_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          if (sel_op == ILLEGAL_OP) begin
            // Rejected opcode never reaches the ALU; the ALU registers keep the last issue
            err_d   = 1'b1;
            out_d   = '0;
            flags_d = '0;
            state_d = RESP;
          end else begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        out_d   = alu_out;
        flags_d = flags_t'(alu_flags);
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
      flags_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_out   = out_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched with the real ALU
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [5:0] req_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [4:0] rsp_out;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [4:0] alu_out;
  logic [3:0] alu_flags;
  logic       busy;
  logic       fz, fn, fo, fc;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign alu_flags = {fz, fn, fo, fc};

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .out(alu_out),
    .z(fz), .n(fn), .o(fo), .c(fc)
  );

  // Reference ALU: {out[4:0], z, n, o, c}
  function automatic logic [8:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] r;
    logic       ov;
    r  = 5'd0;
    ov = 1'b0;
    case (op)
      3'b000: r = {1'b0, a};
      3'b001: begin r = a + b; ov = (a[3] == b[3]) && (r[3] != a[3]); end
      3'b011: begin r = {1'b0, b} - {1'b0, a}; ov = (a[3] != b[3]) && (r[3] != b[3]); end
      3'b100: r = {1'b0, ~a};
      3'b101: r = {1'b0, a & b};
      3'b110: r = {1'b0, a | b};
      3'b111: r = {1'b0, a ^ b};
      default: r = 5'd0;
    endcase
    return {r, (r[3:0] == 4'd0), r[3], ov, r[4]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = 8'h00; req_b = 8'h00; req_op = 6'o00;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    vectors++; if ({rsp_out, rsp_flags, rsp_err} !== 10'd0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_out, rsp_flags, rsp_err}); end
    vectors++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_op}); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    req_valid = 2'b01; req_a = 8'h09; req_b = 8'h0B; req_op = 6'o01;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00; req_a = 8'hFF; req_b = 8'hFF;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_exec rsp_valid %b busy %b want 00 1", rsp_valid, busy); end
    vectors++; if ({alu_a, alu_b, alu_op} !== {4'h9, 4'hB, 3'b001}) begin errors++; $display("FAIL single_alu_regs got %h want %h", {alu_a, alu_b, alu_op}, {4'h9, 4'hB, 3'b001}); end
    tick;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_latency rsp_valid got %b want 01", rsp_valid); end
    vectors++; if (rsp_out !== 5'b10100) begin errors++; $display("FAIL single_out got %b want 10100", rsp_out); end
    vectors++; if (rsp_flags !== 4'b0011 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_flags got %b err %b want 0011 0", rsp_flags, rsp_err); end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_done rsp_valid %b busy %b want 00 0", rsp_valid, busy); end
    tick;
  endtask

  task automatic test_contention;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_valid = 2'b11; req_a = 8'h99; req_b = 8'hBB; req_op = {3'b111, 3'b011};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tie_first_grant got %b want 01", req_ready); end
    tick;
    req_valid = 2'b10;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL tie_exec_ready got %b want 00", req_ready); end
    tick;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b01 || rsp_out !== 5'b00010) begin errors++; $display("FAIL tie_c0_rsp valid %b out %b want 01 00010", rsp_valid, rsp_out); end
    rsp_ready = 2'b10;
    tick;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL tie_nonowner_ready got %b want 01", rsp_valid); end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL tie_second_grant got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    tick;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b10 || rsp_out !== 5'b00010 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL tie_c1_rsp valid %b out %b flags %b want 10 00010 0000", rsp_valid, rsp_out, rsp_flags); end
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
  endtask

  task automatic test_illegal;
    req_valid = 2'b10; req_a = 8'h33; req_b = 8'h55; req_op = {3'b010, 3'b000};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL illegal_grant got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_latency valid %b err %b want 10 1", rsp_valid, rsp_err); end
    vectors++; if (rsp_out !== 5'd0 || rsp_flags !== 4'd0) begin errors++; $display("FAIL illegal_data out %b flags %b want 0 0", rsp_out, rsp_flags); end
    vectors++; if ({alu_a, alu_b, alu_op} !== {4'h9, 4'hB, 3'b111}) begin errors++; $display("FAIL illegal_alu_hold got %h want %h", {alu_a, alu_b, alu_op}, {4'h9, 4'hB, 3'b111}); end
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    req_valid = 2'b01; req_a = 8'h09; req_b = 8'h0B; req_op = 6'o05;
    tick;
    req_valid = 2'b00;
    tick;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_out !== 5'b01001 || rsp_flags !== 4'b0100 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d valid %b out %b flags %b ready %b busy %b want 01 01001 0100 00 1", i, rsp_valid, rsp_out, rsp_flags, req_ready, busy);
      end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid %b busy %b want 00 0", rsp_valid, busy); end
    tick;
  endtask

  task automatic test_reset_mid_exec;
    req_valid = 2'b11; req_a = 8'h12; req_b = 8'h34; req_op = {3'b001, 3'b001};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_pre_grant got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rst_async_ctl busy %b valid %b ready %b want 0 00 00", busy, rsp_valid, req_ready); end
    vectors++; if ({alu_a, alu_b, alu_op, rsp_out, rsp_flags, rsp_err} !== 21'd0) begin errors++; $display("FAIL rst_async_data got %h want 0", {alu_a, alu_b, alu_op, rsp_out, rsp_flags, rsp_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp cycle %0d got %b want 00", i, rsp_valid); end
    end
    tick;
    req_valid = 2'b11;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr_cleared got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [2:0] tab [7];
    logic [2:0] op0, op1, opw;
    logic [3:0] a0, b0, a1, b1;
    logic [8:0] exp;
    logic [1:0] gnt;
    logic       got;
    tab = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int k = 0; k < 10; k++) begin
      a0 = 4'(k * 3 + 1); b0 = 4'(15 - k);
      a1 = b0;            b1 = a0;
      op0 = tab[k % 7];   op1 = tab[(k + 3) % 7];
      gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      opw = (k % 2 == 0) ? op0 : op1;
      exp = (k % 2 == 0) ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
      req_a = {a1, a0}; req_b = {b1, b0}; req_op = {op1, op0};
      req_valid = 2'b11;
      @(negedge clk);
      vectors++; if (req_ready !== gnt) begin errors++; $display("FAIL b2b_grant op %0d got %b want %b", k, req_ready, gnt); end
      tick;
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        @(negedge clk);
        if (rsp_valid !== 2'b00) got = 1'b1;
      end
      vectors++;
      if (!got) begin
        errors++; $display("FAIL b2b_timeout op %0d no rsp_valid within 4 cycles", k);
      end else if (rsp_valid !== gnt || {rsp_out, rsp_flags} !== exp || req_ready !== 2'b00 || alu_op !== opw) begin
        errors++;
        $display("FAIL b2b_rsp op %0d valid %b data %b ready %b aluop %b want %b %b 00 %b", k, rsp_valid, {rsp_out, rsp_flags}, req_ready, alu_op, gnt, exp, opw);
      end
      rsp_ready = 2'b11;
      tick;
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_illegal;
    test_backpressure;
    test_reset_mid_exec;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
